// File: rtl/tx_frame_builder.sv
// Byte-per-clock Ethernet frame generator: preamble, header, RAM payload, CRC-32 FCS
// and inter-frame gap, paced toward the controller through busy.
module tx_frame_builder #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0002_0304_0506,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int          PAYLOAD_LEN = 1024,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic        clk125MHz,
    input  logic        RST,
    input  logic        start_sending,
    input  logic [15:0] segment_num,
    input  logic [7:0]  txid,
    input  logic [7:0]  aux,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, FCS, IFG} state_t;
    typedef enum logic [1:0] {SRC_REG, SRC_RAM, SRC_FCS} src_t;

    localparam logic [15:0] PAYLOAD_LAST = 16'(PAYLOAD_LEN - 1);
    localparam logic [15:0] IFG_LAST     = 16'(IFG_CYCLES - 1);

    state_t       state;
    src_t         src;
    logic [15:0]  cnt;
    logic [15:0]  seg_q;
    logic [7:0]   txid_q;
    logic [7:0]   aux_q;
    logic [7:0]   byte_q;
    logic [1:0]   fcs_idx;
    logic         crc_en;
    logic [31:0]  crc;
    logic [31:0]  crc_next;
    logic [31:0]  fcs_word;
    logic [143:0] hdr_vec;
    logic [143:0] hdr_shift;

    function automatic logic [31:0] crc_update(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    assign hdr_vec   = {DST_MAC, SRC_MAC, ETHERTYPE, txid_q, seg_q, aux_q};
    assign hdr_shift = hdr_vec << {cnt[4:0], 3'b000};
    assign fcs_word  = ~crc;
    assign crc_next  = crc_update(crc, byte_data);

    // Payload bytes come straight from the RAM read port and FCS bytes straight from
    // the CRC register, so both are selected here by registered selectors.
    always_comb begin
        byte_data = byte_q;
        case (src)
            SRC_RAM: byte_data = rd_data;
            SRC_FCS: begin
                case (fcs_idx)
                    2'd0:    byte_data = fcs_word[7:0];
                    2'd1:    byte_data = fcs_word[15:8];
                    2'd2:    byte_data = fcs_word[23:16];
                    default: byte_data = fcs_word[31:24];
                endcase
            end
            default: byte_data = byte_q;
        endcase
    end

    // state/cnt name the byte to emit at the next edge; crc_en marks wire bytes that feed the CRC.
    always_ff @(posedge clk125MHz) begin
        if (RST) begin
            state      <= IDLE;
            src        <= SRC_REG;
            cnt        <= 16'd0;
            seg_q      <= 16'd0;
            txid_q     <= 8'd0;
            aux_q      <= 8'd0;
            byte_q     <= 8'd0;
            fcs_idx    <= 2'd0;
            crc_en     <= 1'b0;
            crc        <= 32'hFFFF_FFFF;
            rd_addr    <= 16'd0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (crc_en) begin
                crc <= crc_next;
            end
            case (state)
                IDLE: begin
                    busy       <= 1'b0;
                    byte_valid <= 1'b0;
                    byte_q     <= 8'd0;
                    src        <= SRC_REG;
                    crc_en     <= 1'b0;
                    rd_addr    <= 16'd0;
                    if (start_sending) begin
                        seg_q  <= segment_num;
                        txid_q <= txid;
                        aux_q  <= aux;
                        crc    <= 32'hFFFF_FFFF;
                        cnt    <= 16'd0;
                        state  <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    busy       <= 1'b1;
                    byte_valid <= 1'b1;
                    src        <= SRC_REG;
                    if (cnt == 16'd7) begin
                        byte_q <= 8'hD5;
                        cnt    <= 16'd0;
                        state  <= HEADER;
                    end else begin
                        byte_q <= 8'h55;
                        cnt    <= cnt + 16'd1;
                    end
                end
                HEADER: begin
                    byte_q <= hdr_shift[143:136];
                    crc_en <= 1'b1;
                    if (cnt == 16'd17) begin
                        rd_addr <= 16'd0;
                        cnt     <= 16'd0;
                        state   <= PAYLOAD;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                PAYLOAD: begin
                    src    <= SRC_RAM;
                    crc_en <= 1'b1;
                    if (cnt == PAYLOAD_LAST) begin
                        rd_addr <= 16'd0;
                        cnt     <= 16'd0;
                        state   <= FCS;
                    end else begin
                        rd_addr <= cnt + 16'd1;
                        cnt     <= cnt + 16'd1;
                    end
                end
                FCS: begin
                    src     <= SRC_FCS;
                    crc_en  <= 1'b0;
                    fcs_idx <= cnt[1:0];
                    if (cnt == 16'd3) begin
                        cnt   <= 16'd0;
                        state <= IFG;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                IFG: begin
                    byte_valid <= 1'b0;
                    byte_q     <= 8'd0;
                    src        <= SRC_REG;
                    if (cnt == IFG_LAST) begin
                        frame_done <= 1'b1;
                        cnt        <= 16'd0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/tx_frame_builder.md
# tx_frame_builder

Byte-stream frame generator sitting directly downstream of the transmit sequencing controller. On each `start_sending` pulse it latches segment number, transmission id and aux byte, then emits one complete Ethernet frame byte-per-clock toward the GMII/RGMII transmit stage: preamble, SFD, MAC header, block header, payload fetched from the segment buffer RAM, and FCS. It holds `busy` high for the whole frame plus the inter-frame gap, which paces the controller.

## Interface
Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC, sent MSB byte first
- SRC_MAC, 48'h0002_0304_0506, source MAC, sent MSB byte first
- ETHERTYPE, 16'h88B5, EtherType field
- PAYLOAD_LEN, 1024, payload bytes per frame; must be ≥ 42 and ≤ 1496
- IFG_CYCLES, 12, idle cycles after FCS, busy still high

Ports:
- clk125MHz  in  1  byte clock
- RST  in  1  synchronous, active-high reset
- start_sending  in  1  one-cycle request; honoured only in IDLE
- segment_num  in  16  segment index, latched on accepted start
- txid  in  8  transmission id, latched on accepted start
- aux  in  8  aux byte, latched on accepted start
- rd_addr  out  16  payload RAM byte address
- rd_data  in  8  payload RAM data, valid 1 cycle after rd_addr
- byte_data  out  8  transmit byte
- byte_valid  out  1  byte_data qualifier (TX_EN)
- busy  out  1  high from first frame byte through last IFG cycle
- frame_done  out  1  one-cycle pulse on last IFG cycle

## Operation
- States: IDLE → PREAMBLE (8 bytes) → HEADER (18) → PAYLOAD (PAYLOAD_LEN) → FCS (4) → IFG (IFG_CYCLES) → IDLE. One byte counter (16 bit), cleared at every state entry.
- PREAMBLE: 7× 0x55, then 0xD5.
- HEADER bytes in order: DST_MAC[47:40..7:0], SRC_MAC[47:40..7:0], ETHERTYPE[15:8], ETHERTYPE[7:0], txid, segment_num[15:8], segment_num[7:0], aux.
- PAYLOAD: byte k = RAM[k], k = 0..PAYLOAD_LEN-1; rd_addr = k issued one cycle ahead of its output cycle. rd_addr holds 0 outside fetch.
- FCS: IEEE 802.3 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement) over HEADER and PAYLOAD bytes only (not preamble/SFD); transmitted crc[7:0] first, crc[31:24] last. CRC updated combinationally per byte, registered each cycle.
- Inputs latched into internal registers on the accepted start; changes afterwards have no effect on the frame in flight.
- start_sending while busy=1 (including IFG and the frame_done cycle) is ignored, not queued.
- Payload byte ordinal k in the header/payload numbering: frame length on wire = 26 + PAYLOAD_LEN + 4 bytes.

## Timing
- Reset values: byte_data=0, byte_valid=0, busy=0, frame_done=0, rd_addr=0, state IDLE, latched fields 0, CRC=0xFFFFFFFF.
- RST in any state: all outputs return to reset values at the same edge; a partial frame is truncated with no FCS.
- Start accepted at edge N (start_sending=1, state IDLE): at edge N+1 busy=1, byte_valid=1, byte_data=0x55.
- Frame byte i (0-based) appears on cycle N+1+i; byte_valid=1 for exactly 30+PAYLOAD_LEN consecutive cycles.
- rd_addr=0 is driven during the cycle of header byte 17 (aux); rd_addr=k during output of payload byte k-1.
- IFG: byte_valid=0, byte_data=0, busy=1 for IFG_CYCLES cycles; frame_done=1 in the last of them.
- busy falls on the cycle after frame_done; a start_sending in that cycle is accepted. Minimum start-to-start spacing = 31+PAYLOAD_LEN+IFG_CYCLES cycles.

## Test plan
- Single frame, PAYLOAD_LEN=46, RAM[k]=k, segment_num=0x1234, txid=2, aux=0x7F → bytes 0x55×7, 0xD5, FF×6, 00 02 03 04 05 06, 88 B5, 02 12 34 7F, 00..2D, FCS matching software CRC-32; 76 valid cycles, 12 gap cycles, frame_done once.
- Input change mid-frame: alter segment_num/txid/aux one cycle after start → header still carries latched values.
- start_sending pulsed every cycle during a frame → exactly one frame; next frame starts byte 0x55 two cycles after frame_done (start on cycle after busy falls).
- RST asserted during payload byte 10 → next cycle byte_valid=0, busy=0, rd_addr=0; subsequent start produces a full, CRC-correct frame.
- RAM model with 1-cycle latency and random data, PAYLOAD_LEN=1024 → payload bytes match RAM in order, no duplicate/skipped address, FCS correct.
- PAYLOAD_LEN=42 minimum → total frame 72 bytes, header/FCS correct, busy high 84 cycles.
